// File: rtl/jam_assign_solver_if.sv
// Bus between the assignment solver and its host.
// Host side (master) drives start/mode and answers the cost lookup;
// solver side (slave) drives the cost-table address and the result fields.
//   start, mode       : run request and min(0)/max(1) selection
//   W, J, Cost        : worker/job address out, cost entry back (same cycle)
//   busy, Valid       : run in progress / results valid
//   BestCost, MatchCount, BestPerm : results (job of worker k at [k*IW +: IW])
interface jam_assign_solver_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned IW     = 3,
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = COST_W + IW,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              mode;
  logic [IW-1:0]     W;
  logic [IW-1:0]     J;
  logic [COST_W-1:0] Cost;
  logic              busy;
  logic              Valid;
  logic [SUM_W-1:0]  BestCost;
  logic [CNT_W-1:0]  MatchCount;
  logic [N*IW-1:0]   BestPerm;

  modport master (
    output start, mode, Cost,
    input  W, J, busy, Valid, BestCost, MatchCount, BestPerm
  );

  modport slave (
    input  start, mode, Cost,
    output W, J, busy, Valid, BestCost, MatchCount, BestPerm
  );
endinterface

// File: rtl/jam_assign_solver.sv
// Exhaustive N x N job-assignment solver. Walks all permutations in
// lexicographic order, sums Cost(k, perm[k]) over N cycles per permutation,
// and keeps the best total, its match count and the first permutation hitting it.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset, aborts any run
//   bus  : jam_assign_solver_if.slave (start/mode in, W/J/Cost lookup, results out)
module jam_assign_solver #(
  parameter int unsigned N      = 8,
  parameter int unsigned IW     = (N <= 2) ? 1 : $clog2(N),
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = COST_W + IW,
  parameter int unsigned CNT_W  = 16
) (
  input logic               CLK,
  input logic               RST,
  jam_assign_solver_if.slave bus
);
  typedef logic [N-1:0][IW-1:0] perm_t;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SUM, S_NEXT, S_DONE} state_t;

  function automatic perm_t identity();
    perm_t p;
    for (int k = 0; k < int'(N); k++) p[k] = IW'(k);
    return p;
  endfunction

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [IW-1:0]     w_q, w_d;
  logic [IW-1:0]     j_q, j_d;
  logic [IW-1:0]     k_q, k_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  best_q, best_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              first_q, first_d;
  perm_t             perm_q, perm_d;
  perm_t             bperm_q, bperm_d;
  logic [SUM_W-1:0]  best_cost_q, best_cost_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  perm_t             best_perm_q, best_perm_d;

  logic              accept;
  logic              last_k;
  logic [IW-1:0]     k_nx;
  logic              better;

  assign accept = bus.start && !busy_q && (state_q == S_IDLE);
  assign last_k = (k_q == IW'(N - 1));
  assign k_nx   = k_q + IW'(1);

  // Next lexicographic permutation of perm_q
  logic          has_pivot;
  logic [IW-1:0] piv, succ;
  perm_t         swp, nxt;
  always_comb begin
    has_pivot = 1'b0;
    piv       = '0;
    succ      = '0;
    for (int i = 0; i < int'(N) - 1; i++)
      if (perm_q[i] < perm_q[i+1]) begin
        has_pivot = 1'b1;
        piv       = IW'(i);
      end
    for (int j = 0; j < int'(N); j++)
      if ((IW'(j) > piv) && (perm_q[j] > perm_q[piv])) succ = IW'(j);
    swp       = perm_q;
    swp[piv]  = perm_q[succ];
    swp[succ] = perm_q[piv];
    // Tail after the pivot is descending; reversing it makes it ascending.
    nxt = swp;
    for (int p = 0; p < int'(N) - 1; p++)
      for (int k = p + 1; k < int'(N); k++)
        if (piv == IW'(p)) nxt[k] = swp[int'(N) + p - k];
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_INIT;
      S_INIT:  state_d = S_SUM;
      S_SUM:   if (last_k) state_d = S_NEXT;
      S_NEXT:  state_d = has_pivot ? S_SUM : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mode_d        = mode_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    w_d           = w_q;
    j_d           = j_q;
    k_d           = k_q;
    acc_d         = acc_q;
    best_d        = best_q;
    count_d       = count_q;
    first_d       = first_q;
    perm_d        = perm_q;
    bperm_d       = bperm_q;
    best_cost_d   = best_cost_q;
    match_count_d = match_count_q;
    best_perm_d   = best_perm_q;
    better        = mode_q ? (acc_q > best_q) : (acc_q < best_q);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = bus.mode;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_INIT: begin
        perm_d  = identity();
        bperm_d = identity();
        best_d  = mode_q ? '0 : '1;
        count_d = '0;
        first_d = 1'b1;
        acc_d   = '0;
        k_d     = '0;
        w_d     = '0;
        j_d     = '0;
      end
      S_SUM: begin
        // W/J were registered one cycle ahead, so Cost matches worker k_q now.
        acc_d = acc_q + SUM_W'(bus.Cost);
        if (!last_k) begin
          k_d = k_nx;
          w_d = k_nx;
          j_d = perm_q[k_nx];
        end
      end
      S_NEXT: begin
        first_d = 1'b0;
        if (first_q || better) begin
          best_d  = acc_q;
          count_d = CNT_W'(1);
          bperm_d = perm_q;
        end else if (acc_q == best_q) begin
          count_d = count_q + CNT_W'(1);
        end
        acc_d = '0;
        k_d   = '0;
        if (has_pivot) begin
          perm_d = nxt;
          w_d    = '0;
          j_d    = nxt[0];
        end
      end
      S_DONE: begin
        best_cost_d   = best_q;
        match_count_d = count_q;
        best_perm_d   = bperm_q;
        valid_d       = 1'b1;
        busy_d        = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q        <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      w_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      best_q        <= '1;
      count_q       <= '0;
      first_q       <= 1'b1;
      perm_q        <= identity();
      bperm_q       <= identity();
      best_cost_q   <= '1;
      match_count_q <= '0;
      best_perm_q   <= identity();
    end else begin
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      w_q           <= w_d;
      j_q           <= j_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      best_q        <= best_d;
      count_q       <= count_d;
      first_q       <= first_d;
      perm_q        <= perm_d;
      bperm_q       <= bperm_d;
      best_cost_q   <= best_cost_d;
      match_count_q <= match_count_d;
      best_perm_q   <= best_perm_d;
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.BestCost   = best_cost_q;
  assign bus.MatchCount = match_count_q;
  assign bus.BestPerm   = best_perm_q;
endmodule
